// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the multi-cycle data memory controller: access ops,
// controller states and op normalisation.
package dm_ctrl_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StWait,
        StResp
    } dm_state_e;

    // Undefined op codes are treated as word accesses.
    function automatic logic [2:0] dm_norm_op(input logic [2:0] op);
        return (op > DM_BU) ? DM_W : op;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for the data memory: store byte enables and merge,
// load lane select with sign/zero extension.
module dm_lane
    import dm_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wr_word_o,
    output logic [31:0] ld_data_o
);

    logic [2:0]  op_n;
    logic [31:0] wide;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        op_n = dm_norm_op(op_i);
        be_o = 4'b1111;
        wide = wdata_i;
        case (op_n)
            DM_B, DM_BU: begin
                be_o = 4'b0001 << addr_lo_i;
                wide = {4{wdata_i[7:0]}};
            end
            DM_H, DM_HU: begin
                be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wide = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word_o[8*i +: 8] = be_o[i] ? wide[8*i +: 8] : old_word_i[8*i +: 8];
        end

        byte_sel = rd_word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
        case (op_n)
            DM_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   ld_data_o = {24'h0, byte_sel};
            DM_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
            DM_HU:   ld_data_o = {16'h0, half_sel};
            default: ld_data_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Multi-cycle data memory with valid/ready request/response handshakes,
// configurable latency, alignment/range exceptions and a power-up clear.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic        init_done
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    dm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              exc_q, exc_d, done_q, done_d;

    logic [31:0] mem [Depth];

    // With LATENCY=1 the access completes on the accept edge, so the live
    // request is used instead of the latched copy.
    logic              in_idle;
    logic [2:0]        sel_op, sel_op_n;
    logic [31:0]       sel_addr, sel_wdata, sel_pc, off;
    logic              sel_we, exc, go_resp, commit;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word, wr_word, ld_data;
    logic [3:0]        be;

    assign in_idle   = (state_q == StIdle);
    assign sel_op    = in_idle ? req_op : op_q;
    assign sel_addr  = in_idle ? req_addr : addr_q;
    assign sel_wdata = in_idle ? req_wdata : wdata_q;
    assign sel_pc    = in_idle ? req_pc : pc_q;
    assign sel_we    = in_idle ? req_we : we_q;
    assign sel_op_n  = dm_norm_op(sel_op);
    assign off       = sel_addr - BASE;
    assign idx       = off[ADDR_W+1:2];
    assign old_word  = mem[idx];

    assign exc = (((sel_op_n == DM_H) || (sel_op_n == DM_HU)) && sel_addr[0])
               || ((sel_op_n == DM_W) && (sel_addr[1:0] != 2'b00))
               || ((off >> (ADDR_W + 2)) != 32'd0);

    assign go_resp = (in_idle && req_valid && (LATENCY == 1))
                   || ((state_q == StWait) && (cnt_q == 4'd1));
    assign commit  = go_resp && sel_we && !exc;

    dm_lane u_lane (
        .op_i       (sel_op),
        .addr_lo_i  (sel_addr[1:0]),
        .wdata_i    (sel_wdata),
        .old_word_i (old_word),
        .rd_word_i  (old_word),
        .be_o       (be),
        .wr_word_o  (wr_word),
        .ld_data_o  (ld_data)
    );

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        done_d  = done_q;
        case (state_q)
            StInit: begin
                clr_d = clr_q + 1'b1;
                if (&clr_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    we_d    = req_we;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
        if (go_resp) begin
            rdata_d = (exc || sel_we) ? 32'h0 : ld_data;
            exc_d   = exc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            clr_q   <= '0;
            cnt_q   <= 4'd0;
            op_q    <= DM_W;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pc_q    <= 32'h0;
            we_q    <= 1'b0;
            rdata_q <= 32'h0;
            exc_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            done_q  <= done_d;
        end
    end

    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    assign mem_we    = rst_n && ((state_q == StInit) || commit);
    assign mem_idx   = (state_q == StInit) ? clr_q : idx;
    assign mem_wdata = (state_q == StInit) ? 32'h0 : wr_word;
    assign mem_be    = (state_q == StInit) ? 4'b1111 : be;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
        if (rst_n && commit) begin
            $display("@%h: *%h <= %h", sel_pc, {sel_addr[31:2], 2'b00}, wr_word);
        end
    end

    assign req_ready = in_idle;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_exc   = exc_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: a LATENCY=1 instance driven from a vector table and
// a LATENCY=3 instance for back-pressure and mid-access reset sequences.
module tb_dm_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b1;
    logic [2:0]  a_req_op = 3'd0;
    logic [31:0] a_req_addr = 32'h0, a_req_wdata = 32'h0, a_req_pc = 32'h0;
    logic        a_req_ready, a_rsp_valid, a_rsp_exc, a_init_done;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
    logic [2:0]  b_req_op = 3'd0;
    logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0, b_req_pc = 32'h0;
    logic        b_req_ready, b_rsp_valid, b_rsp_exc, b_init_done;
    logic [31:0] b_rsp_rdata;

    int errors = 0;
    int checks = 0;

    dm_ctrl #(.ADDR_W(12), .LATENCY(1), .BASE(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_op(a_req_op), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_pc(a_req_pc), .rsp_valid(a_rsp_valid),
        .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_exc(a_rsp_exc),
        .init_done(a_init_done)
    );

    dm_ctrl #(.ADDR_W(12), .LATENCY(3), .BASE(32'h0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_op(b_req_op), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_pc(b_req_pc), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_exc(b_rsp_exc),
        .init_done(b_init_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request and response must never be offered together.
    always @(negedge clk) begin
        if (rst_n && ((a_rsp_valid && a_req_ready) || (b_rsp_valid && b_req_ready))) begin
            errors++;
            $display("FAIL overlap: rsp_valid and req_ready both 1 at %0t", $time);
        end
    end

    // Counts negedges spent in INIT (req_ready low), starting at the release edge.
    task automatic wait_init(output int n);
        n = 0;
        while (!a_req_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_a(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic ex, output int lat);
        chk("a_ready_before", {31'h0, a_req_ready}, 32'd1);
        a_req_we = we; a_req_op = op; a_req_addr = addr;
        a_req_wdata = wdata; a_req_pc = 32'h0000_0400 + addr;
        a_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = a_rsp_rdata;
        ex = a_rsp_exc;
        @(negedge clk);
    endtask

    task automatic do_b(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output int lat);
        b_req_we = we; b_req_op = op; b_req_addr = addr;
        b_req_wdata = wdata; b_req_pc = 32'h0000_0800 + addr;
        b_req_valid = 1'b1;
        b_rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        lat = 1;
        while (!b_rsp_valid && lat < 20) begin
            chk("b_ready_in_wait", {31'h0, b_req_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        rd = b_rsp_rdata;
        chk("b_exc", {31'h0, b_rsp_exc}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("b_valid_held", {31'h0, b_rsp_valid}, 32'd1);
            chk("b_rdata_stable", b_rsp_rdata, rd);
            chk("b_ready_held", {31'h0, b_req_ready}, 32'd0);
        end
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
        chk("b_valid_after_hs", {31'h0, b_rsp_valid}, 32'd0);
        chk("b_ready_after_hs", {31'h0, b_req_ready}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exc;
    } vec_t;

    localparam int NumVec = 23;
    vec_t vecs [NumVec];

    initial begin
        int          n;
        int          lat;
        logic [31:0] rd;
        logic        ex;

        vecs[0]  = '{1'b0, 3'd0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
        vecs[3]  = '{1'b1, 3'd3, 32'h0000_0013, 32'h5555_55AB, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 3'd3, 32'h0000_0013, 32'h0,         32'hFFFF_FFAB, 1'b0};
        vecs[5]  = '{1'b0, 3'd4, 32'h0000_0013, 32'h0,         32'h0000_00AB, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'hAB34_5678, 1'b0};
        vecs[7]  = '{1'b1, 3'd1, 32'h0000_0011, 32'h0000_BEEF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 3'd0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'hAB34_5678, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 32'h0000_4000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 3'd0, 32'h0000_4000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 3'd1, 32'h0000_0016, 32'hDEAD_8001, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 3'd1, 32'h0000_0016, 32'h0,         32'hFFFF_8001, 1'b0};
        vecs[14] = '{1'b0, 3'd2, 32'h0000_0016, 32'h0,         32'h0000_8001, 1'b0};
        vecs[15] = '{1'b0, 3'd1, 32'h0000_0014, 32'h0,         32'h0000_0000, 1'b0};
        vecs[16] = '{1'b1, 3'd4, 32'h0000_0015, 32'hFFFF_FF7F, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 3'd0, 32'h0000_0014, 32'h0,         32'h8001_7F00, 1'b0};
        vecs[18] = '{1'b0, 3'd3, 32'h0000_0015, 32'h0,         32'h0000_007F, 1'b0};
        vecs[19] = '{1'b0, 3'd7, 32'h0000_0014, 32'h0,         32'h8001_7F00, 1'b0};
        vecs[20] = '{1'b0, 3'd7, 32'h0000_0015, 32'h0,         32'h0000_0000, 1'b1};
        vecs[21] = '{1'b0, 3'd2, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1};
        vecs[22] = '{1'b0, 3'd3, 32'h0000_0017, 32'h0,         32'hFFFF_FF80, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {31'h0, a_req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("rst_rsp_exc", {31'h0, a_rsp_exc}, 32'd0);
        chk("rst_init_done", {31'h0, a_init_done}, 32'd0);

        // Request held during INIT must be ignored.
        a_req_valid = 1'b1; a_req_op = 3'd0; a_req_addr = 32'h100; a_req_we = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_init(n);
        a_req_valid = 1'b0;
        chk("init_cycles", n, 32'd4096);
        chk("init_done_a", {31'h0, a_init_done}, 32'd1);
        chk("init_done_b", {31'h0, b_init_done}, 32'd1);
        chk("rsp_valid_after_init", {31'h0, a_rsp_valid}, 32'd0);

        for (int i = 0; i < NumVec; i++) begin
            do_a(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, ex, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd1);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_exc", i), {31'h0, ex}, {31'h0, vecs[i].exc});
        end

        // LATENCY=3 with response back-pressure.
        do_b(1'b1, 3'd0, 32'h0000_0020, 32'hCAFE_F00D, 5, rd, lat);
        chk("b_sw_latency", lat, 32'd3);
        chk("b_sw_rdata", rd, 32'h0);
        do_b(1'b0, 3'd0, 32'h0000_0020, 32'h0, 5, rd, lat);
        chk("b_lw_latency", lat, 32'd3);
        chk("b_lw_rdata", rd, 32'hCAFE_F00D);

        // Reset while a store sits in WAIT.
        b_req_we = 1'b1; b_req_op = 3'd0; b_req_addr = 32'h0000_0024;
        b_req_wdata = 32'h1111_1111; b_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("b_in_wait", {31'h0, b_rsp_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'h0, b_req_ready}, 32'd0);
        chk("mid_rst_init_done", {31'h0, b_init_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n);
        chk("reinit_cycles", n, 32'd4096);
        chk("reinit_done_b", {31'h0, b_init_done}, 32'd1);
        do_b(1'b0, 3'd0, 32'h0000_0024, 32'h0, 1, rd, lat);
        chk("b_dropped_store", rd, 32'h0);
        do_b(1'b0, 3'd0, 32'h0000_0020, 32'h0, 0, rd, lat);
        chk("b_reinit_cleared", rd, 32'h0);
        do_a(1'b0, 3'd0, 32'h0000_0010, 32'h0, rd, ex, lat);
        chk("a_reinit_cleared", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
